// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package mult_div_unit_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int COUNT_W       = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Per-operation context captured at the start edge.
    typedef struct packed {
        op_e  op;
        logic neg;       // operand signs differ: negate the magnitude result
        logic div_zero;  // divisor was zero
    } op_ctx_t;

endpackage

// File: rtl/mult_div_unit_add_sub.sv
// Shared iteration adder: sum = a + b, or a - b when sub is set.
// For subtraction cout = 1 means no borrow (a >= b unsigned).
module add_sub_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiplier / divider: radix-2 shift-add multiply and
// restoring divide on magnitudes, one iteration per cycle, WIDTH iterations.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [COUNT_W-1:0] LAST_ITER = COUNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q;
    op_ctx_t            ctx_q;
    logic [WIDTH-1:0]   mag_a_q, mag_b_q;
    logic [WIDTH-1:0]   acc_q, lo_q;

    logic             start;
    logic [WIDTH-1:0] in_mag_a, in_mag_b;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign in_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign in_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A start always wins: it (re)launches from any state, aborting silently.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (start)                   state_d = RUN;
                else if (cnt_q == LAST_ITER) state_d = DONE;
            end
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- iteration datapath ----------------
    logic [WIDTH-1:0] div_shift;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_sub, add_cout;
    logic [WIDTH-1:0] acc_d, lo_d;

    // Restoring divide: remainder/quotient pair shifted left one bit.
    assign div_shift = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign add_sub   = (ctx_q.op == OP_DIV);
    assign add_a     = add_sub ? div_shift : acc_q;
    assign add_b     = add_sub ? mag_b_q   : mag_a_q;

    add_sub_32 #(.WIDTH(WIDTH)) u_add_sub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        if (ctx_q.op == OP_MUL) begin
            // Product {acc, lo}: add multiplicand on LSB of multiplier, shift right.
            if (lo_q[0]) begin
                acc_d = {add_cout, add_sum[WIDTH-1:1]};
                lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[WIDTH-1:1]};
                lo_d  = {acc_q[0], lo_q[WIDTH-1:1]};
            end
        end else begin
            // No borrow means the trial subtraction stands and the quotient bit is 1.
            acc_d = add_cout ? add_sum : div_shift;
            lo_d  = {lo_q[WIDTH-2:0], add_cout};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            ctx_q   <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
        end else if (start) begin
            cnt_q          <= '0;
            ctx_q.op       <= ctrl_MULT ? OP_MUL : OP_DIV;
            ctx_q.neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            ctx_q.div_zero <= (data_operandB == '0);
            mag_a_q        <= in_mag_a;
            mag_b_q        <= in_mag_b;
            acc_q          <= '0;
            lo_q           <= ctrl_MULT ? in_mag_b : in_mag_a;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + COUNT_W'(1);
            acc_q <= acc_d;
            lo_q  <= lo_d;
        end
    end

    // ---------------- sign correction and exceptions ----------------
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH:0]     prod_hi;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_exc;

    assign prod_s  = ctx_q.neg ? -{acc_q, lo_q} : {acc_q, lo_q};
    assign quo_s   = ctx_q.neg ? -lo_q : lo_q;
    assign prod_hi = prod_s[2*WIDTH-1:WIDTH-1];

    always_comb begin
        fin_res = '0;
        fin_exc = 1'b0;
        if (ctx_q.op == OP_MUL) begin
            fin_res = prod_s[WIDTH-1:0];
            fin_exc = !((&prod_hi) || !(|prod_hi));
        end else if (ctx_q.div_zero) begin
            fin_res = '0;
            fin_exc = 1'b1;
        end else begin
            // A positive quotient with the top bit set only arises from MIN / -1.
            fin_res = quo_s;
            fin_exc = !ctx_q.neg && lo_q[WIDTH-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (state_q == DONE && !start) begin
            data_result    <= fin_res;
            data_exception <= fin_exc;
            data_resultRDY <= 1'b1;
        end else begin
            data_resultRDY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, expected results queued
// at issue time and checked by an independent monitor on each RDY strobe.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   rdy_seen = 0;
    int   rdy_expected = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every RDY strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            exp_t e;
            rdy_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: result 0x%08h at cycle %0d with nothing outstanding",
                         data_result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result",    data_result, e.res);
                chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
                chk("latency",   cyc, e.due);
            end
        end
    end

    // Drive a start in the current low phase; the next rising edge samples it.
    task automatic issue(input logic mul, input logic dv, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_rdy,
                         input logic [31:0] er, input logic ee);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = dv;
        if (expect_rdy) begin
            e.res = er;
            e.exc = ee;
            e.due = cyc + 1 + 33;
            sb.push_back(e);
            rdy_expected++;
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        // Scramble operands during RUN; the unit must ignore them.
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic start_op(input logic mul, input logic [31:0] a, input logic [31:0] b,
                            input bit expect_rdy, input logic [31:0] er, input logic ee);
        @(negedge clock);
        issue(mul, !mul, a, b, expect_rdy, er, ee);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        #3 reset = 1'b1;
        #4;
        chk("reset_result", data_result, 32'h0);
        chk("reset_exc",    {31'b0, data_exception}, 32'h0);
        chk("reset_rdy",    {31'b0, data_resultRDY}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        start_op(1'b1, 32'd1646, 32'd5184, 1'b1, 32'd8532864, 1'b0);
        wait_done();
        start_op(1'b1, -32'sd7, 32'd6, 1'b1, 32'hFFFF_FFD6, 1'b0);
        wait_done();
        start_op(1'b1, 32'd65536, 32'd65536, 1'b1, 32'h0, 1'b1);
        wait_done();
        start_op(1'b0, 32'd5184, 32'd1646, 1'b1, 32'd3, 1'b0);
        wait_done();
        start_op(1'b0, -32'sd817648, 32'd267482, 1'b1, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        start_op(1'b0, 32'd267482, 32'd0, 1'b1, 32'h0, 1'b1);
        wait_done();
        start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
        wait_done();

        repeat (5) @(negedge clock);
        chk("hold_result", data_result, 32'h8000_0000);
        chk("hold_exc",    {31'b0, data_exception}, 32'h1);

        // Multiply aborted by a divide ten cycles later: only the divide reports.
        start_op(1'b1, 32'd3, 32'd4, 1'b0, 32'h0, 1'b0);
        repeat (8) @(negedge clock);
        start_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        wait_done();

        // Reset in the middle of a multiply discards it.
        start_op(1'b1, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0);
        repeat (18) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_result", data_result, 32'h0);
        chk("midreset_exc",    {31'b0, data_exception}, 32'h0);
        chk("midreset_rdy",    {31'b0, data_resultRDY}, 32'h0);
        @(negedge clock);
        // Release reset with a start on the first edge; both controls high means multiply.
        reset = 1'b0;
        issue(1'b1, 1'b1, 32'd2, 32'd2, 1'b1, 32'd4, 1'b0);
        wait_done();

        repeat (40) @(negedge clock);
        chk("rdy_count", rdy_seen, rdy_expected);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have port clock, input, 1, the sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port data_operandA, input, WIDTH, two's-complement multiplicand or dividend.
REQ-005 The block SHALL have port data_operandB, input, WIDTH, two's-complement multiplier or divisor.
REQ-006 The block SHALL have port ctrl_MULT, input, 1, single-cycle start pulse for a signed multiply.
REQ-007 The block SHALL have port ctrl_DIV, input, 1, single-cycle start pulse for a signed divide.
REQ-008 The block SHALL have port data_result, output, WIDTH, the low WIDTH bits of the product, or the quotient.
REQ-009 The block SHALL have port data_exception, output, 1, which flags multiply overflow or an invalid divide.
REQ-010 The block SHALL have port data_resultRDY, output, 1, a one-cycle completion strobe.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE, encoded in 2 bits.
REQ-012 Start handling: a start sampled at edge N SHALL latch both operands and the op type, clear the 6-bit counter and enter RUN.
REQ-013 Operands SHALL be sampled only at the start edge; input changes during RUN are ignored.
REQ-014 RUN SHALL perform one iteration per cycle for WIDTH cycles, with the counter running 0 to WIDTH-1.
REQ-015 When the counter reaches WIDTH-1, the block SHALL enter DONE.
REQ-016 DONE SHALL last exactly one cycle and SHALL return to IDLE unless a new start is present.
REQ-017 Latency: data_resultRDY SHALL be high only in the cycle following edge N+WIDTH+1 (33 cycles for WIDTH=32).
REQ-018 data_result and data_exception SHALL be registered and SHALL hold their value until the next DONE or reset.
REQ-019 Multiply SHALL use a radix-2 shift-add on magnitudes with sign correction, producing a 2*WIDTH-bit product.
REQ-020 Multiply exception SHALL be set when the upper WIDTH+1 bits of the product are not all equal (signed overflow).
REQ-021 Divide SHALL use restoring division on magnitudes with the quotient truncated toward zero; the remainder is discarded.
REQ-022 Divide by zero SHALL set data_result = 0 and data_exception = 1, with normal latency.
REQ-023 A divide of the most negative value by -1 SHALL give data_result = 0x80000000 and data_exception = 1.
REQ-024 If ctrl_MULT and ctrl_DIV are high in the same cycle, the block SHALL perform a multiply.
REQ-025 A start during RUN or DONE SHALL abort the current operation silently, with no RDY, and restart per REQ-012.

Reset
REQ-026 Reset SHALL asynchronously force state IDLE, counter 0, data_result 0, data_exception 0 and data_resultRDY 0.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no RDY SHALL follow its release.
REQ-028 A start pulse coincident with the first edge after reset release SHALL be accepted.

Structure
REQ-029 A shared package SHALL hold WIDTH_DEFAULT = 32, the state encodings (IDLE = 0, RUN = 1, DONE = 2) and COUNT_W = 6.
REQ-030 The iteration add/subtract SHALL be one sub-module, add_sub_32, shared by both ops with a subtract control input.

Verification
REQ-031 Scenario: MULT with A=1646, B=5184 -> result 8532864, exception 0, RDY exactly 33 cycles after the start edge.
REQ-032 Scenario: MULT with A=-7, B=6 -> result 0xFFFFFFD6 (-42), exception 0; then MULT with A=65536, B=65536 -> result 0, exception 1.
REQ-033 Scenario: DIV with A=5184, B=1646 -> result 3; then DIV with A=-817648, B=267482 -> result -3; exception 0 for both.
REQ-034 Scenario: DIV with A=267482, B=0 -> result 0, exception 1; then DIV with A=0x80000000, B=-1 -> result 0x80000000, exception 1.
REQ-035 Scenario: MULT with A=3, B=4 restarted by DIV with A=100, B=7 at cycle 10 -> a single RDY 33 cycles after the restart, result 14.
REQ-036 Scenario: reset pulsed at cycle 20 of a MULT -> all outputs 0 and no RDY; a following MULT with A=2, B=2 -> result 4.
